// File: rtl/mem_bus_responder.sv
// mem_bus_responder: single-initiator main-memory endpoint.
// Accepts one request at a time, models a word-wide SRAM with a fixed access
// latency, and returns a one-cycle data_valid completion for reads and writes.
// Optional build macro: MEM_RESP_RANGE_CHECK_EN
//   defined   -> accesses with nonzero address bits above the array are
//                flagged on addr_err; writes are dropped and reads return 0.
//   undefined -> upper address bits are ignored (addresses alias modulo depth).
module mem_bus_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wrt_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    TURN
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Request holding registers, loaded only in IDLE.
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    oor_q, oor_d;

  // Registered completion outputs.
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    addr_err_q, addr_err_d;

  // Storage array; contents are deliberately not reset.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_rd;
  logic                    commit;
  logic                    mem_we;
  logic                    req_oor;

  // Byte-offset bits are ignored; upper bits are ignored unless range-checked.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{addr[1:0], addr[ADDR_WIDTH-1:DEPTH_LOG2+2]};

  // Classify the incoming request address.
`ifdef MEM_RESP_RANGE_CHECK_EN
  assign req_oor = |addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
`else
  assign req_oor = 1'b0;
`endif

  // The access completes on the edge that leaves ACCESS with the counter at 0.
  assign commit = (state_q == ACCESS) && (cnt_q == '0);
  assign mem_we = commit && we_q && !oor_q;
  assign mem_rd = mem[idx_q];

  // Next-state, counter and holding-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = addr[DEPTH_LOG2+1:2];
          we_d    = we;
          wdata_d = wrt_data;
          oor_d   = req_oor;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion outputs: read data updates only on a read commit.
  always_comb begin
    rd_data_d    = rd_data_q;
    data_valid_d = commit;
    addr_err_d   = commit && oor_q;
    if (commit && !we_q) begin
      rd_data_d = oor_q ? '0 : mem_rd;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      oor_q        <= 1'b0;
      rd_data_q    <= '0;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      oor_q        <= oor_d;
      rd_data_q    <= rd_data_d;
      data_valid_q <= data_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Array write; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign busy       = (state_q != IDLE);
  assign rd_data    = rd_data_q;
  assign data_valid = data_valid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed steps plus randomized
// transactions checked against a word-array reference model.
module tb_mem_bus_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wrt_data;
  logic [31:0] rd_data, rd_data1, rd_data15;
  logic        data_valid, data_valid1, data_valid15;
  logic        busy, busy1, busy15;
  logic        addr_err, addr_err1, addr_err15;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [31:0] mem_m [1024];
  bit          known_m [1024];
  logic [31:0] last_rd;
  bit          last_known;

  mem_bus_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .addr(addr), .we(we),
    .wrt_data(wrt_data), .rd_data(rd_data), .data_valid(data_valid),
    .busy(busy), .addr_err(addr_err));

  mem_bus_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .addr(addr), .we(we),
    .wrt_data(wrt_data), .rd_data(rd_data1), .data_valid(data_valid1),
    .busy(busy1), .addr_err(addr_err1));

  mem_bus_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(15)) dut15 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .addr(addr), .we(we),
    .wrt_data(wrt_data), .rd_data(rd_data15), .data_valid(data_valid15),
    .busy(busy15), .addr_err(addr_err15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
`ifdef MEM_RESP_RANGE_CHECK_EN
    return (a >> 12) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  // One complete transaction with latency, data and turnaround checks.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
    int          k;
    bit          seen;
    logic [31:0] exp_rd;
    bit          exp_known;
    logic        exp_err;
    exp_err = !in_range(a);
    if (w) begin
      if (!exp_err) begin
        mem_m[widx(a)]   = d;
        known_m[widx(a)] = 1'b1;
      end
      exp_rd    = last_rd;
      exp_known = last_known;
    end else if (exp_err) begin
      exp_rd    = 32'h0;
      exp_known = 1'b1;
    end else begin
      exp_rd    = mem_m[widx(a)];
      exp_known = known_m[widx(a)];
    end
    req_valid = 1'b1; we = w; addr = a; wrt_data = d;
    tick();
    req_valid = 1'b0;
    chk({tag, ":busy_capture"}, 32'(busy), 32'd1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < LAT + 10) begin
      tick();
      k++;
      if (data_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, ":latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(LAT));
    if (seen) begin
      chk({tag, ":addr_err"}, 32'(addr_err), 32'(exp_err));
      if (exp_known) chk({tag, ":rd_data"}, rd_data, exp_rd);
    end
    last_rd    = exp_rd;
    last_known = exp_known;
    tick();
    chk({tag, ":dv_width"}, 32'(data_valid), 32'd0);
    chk({tag, ":busy_turn"}, 32'(busy), 32'd1);
    tick();
    chk({tag, ":busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          f1, f2, f15, n1, n2, n15;
    int          np, p1, p2;
    logic [31:0] d1, d2;
    logic        w;
    logic [31:0] a, up, lo, ix;

    reset = 1'b0; req_valid = 1'b1; we = 1'b0; addr = '0; wrt_data = '0;
    last_rd = '0; last_known = 1'b1;

    // Reset held with a pending request: nothing starts.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset:data_valid", 32'(data_valid), 32'd0);
      chk("reset:busy", 32'(busy), 32'd0);
      chk("reset:rd_data", rd_data, 32'h0);
    end

    // Latency sweep: one write request seen by all three latency variants.
    reset = 1'b1; we = 1'b1; addr = 32'h0; wrt_data = 32'h5A5A_0000;
    tick();
    req_valid = 1'b0;
    mem_m[0] = 32'h5A5A_0000; known_m[0] = 1'b1;
    f1 = 0; f2 = 0; f15 = 0; n1 = 0; n2 = 0; n15 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (data_valid1 === 1'b1)  begin n1++;  if (f1 == 0)  f1 = k;  end
      if (data_valid === 1'b1)   begin n2++;  if (f2 == 0)  f2 = k;  end
      if (data_valid15 === 1'b1) begin n15++; if (f15 == 0) f15 = k; end
    end
    chk("sweep:lat1_edge", 32'(f1), 32'd1);
    chk("sweep:lat1_width", 32'(n1), 32'd1);
    chk("sweep:lat2_edge", 32'(f2), 32'd2);
    chk("sweep:lat2_width", 32'(n2), 32'd1);
    chk("sweep:lat15_edge", 32'(f15), 32'd15);
    chk("sweep:lat15_width", 32'(n15), 32'd1);
    chk("sweep:lat15_idle", 32'(busy15), 32'd0);

    // Write then read of the same word.
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, "wr10");
    txn(1'b0, 32'h10, 32'h0, "rd10");

    // Back-to-back reads with req_valid held high.
    txn(1'b1, 32'h0, 32'h11, "pre0");
    txn(1'b1, 32'h4, 32'h22, "pre4");
    we = 1'b0; addr = 32'h0; req_valid = 1'b1;
    tick();
    addr = 32'h4;
    np = 0; p1 = 0; p2 = 0; d1 = '0; d2 = '0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 10) req_valid = 1'b0;
      tick();
      if (data_valid === 1'b1) begin
        np++;
        if (np == 1) begin p1 = k; d1 = rd_data; end
        else if (np == 2) begin p2 = k; d2 = rd_data; end
      end
    end
    chk("b2b:first_edge", 32'(p1), 32'd2);
    chk("b2b:second_edge", 32'(p2), 32'd7);
    chk("b2b:pulses", 32'(np), 32'd2);
    chk("b2b:data0", d1, 32'h11);
    chk("b2b:data4", d2, 32'h22);
    chk("b2b:idle", 32'(busy), 32'd0);
    last_rd = 32'h22; last_known = 1'b1;

    // Reset landing on the commit edge of a write aborts it.
    txn(1'b1, 32'h20, 32'hAA, "wr20a");
    req_valid = 1'b1; we = 1'b1; addr = 32'h20; wrt_data = 32'h55;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    reset = 1'b0;
    tick();
    chk("abort:data_valid", 32'(data_valid), 32'd0);
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:rd_data", rd_data, 32'h0);
    reset = 1'b1;
    tick();
    last_rd = 32'h0; last_known = 1'b1;
    txn(1'b0, 32'h20, 32'h0, "rd20_after_abort");

    // Address beyond the array: aliases, or flagged when range-checked.
    txn(1'b1, 32'h1000, 32'h77, "wr_oor");
    txn(1'b0, 32'h1000, 32'h0, "rd_oor");
    txn(1'b0, 32'h0, 32'h0, "rd0_alias");

    // Randomized traffic over a small seeded pool of words.
    for (int i = 0; i < 16; i++) txn(1'b1, 32'(i * 4), $urandom, "seed");
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom);
      ix = $urandom % 16;
      lo = $urandom % 4;
      up = (($urandom % 4) == 0) ? $urandom_range(1, 32'hFFFFF) : 32'h0;
      a  = (up << 12) | (ix << 2) | lo;
      repeat ($urandom % 3) tick();
      txn(w, a, $urandom, w ? "rand_wr" : "rand_rd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
